gray_counter: RTL and testbench

Parametrised N-bit up/down counter that keeps a binary count and its Gray-code image in registers that update on the same clock edge. It supports synchronous load from either a binary or a Gray-coded value, with load-time Gray-to-binary conversion, and a wrap or saturate end-of-range mode. It is the sequential successor to the team's combinational binary/Gray converters. Typical uses are async-FIFO pointers, position encoders and step sequencers.

---
 rtl/gray_counter.sv | 45 ++++
 tb/tb_gray_counter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter: N-bit up/down counter with registered binary and Gray outputs,
// binary or Gray-coded synchronous load, and wrap or saturate at the range ends.
module gray_counter #(
    parameter int N    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic         load_gray,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         tc,
    output logic         wrap_pulse
);
    logic [N-1:0] load_bin;
    logic [N-1:0] next_b;
    logic         step;
    // each binary bit is the XOR of all Gray bits at or above its position
    for (genvar i = 0; i < N; i++) begin : g_g2b
        assign load_bin[i] = ^(load_val >> i);
    end
    always_comb begin
        tc     = up ? &bin_out : ~|bin_out;
        step   = en && !load && !(tc && !WRAP);
        next_b = load ? (load_gray ? load_bin : load_val)
               : step ? (up ? bin_out + N'(1) : bin_out - N'(1))
               : bin_out;
    end
    // Gray is registered from next_b so both outputs change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out    <= '0;
            gray_out   <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            bin_out    <= next_b;
            gray_out   <= next_b ^ (next_b >> 1);
            wrap_pulse <= step && tc;
        end
    end
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed scoreboard bench; one wrapping and one saturating
// instance share stimulus, and each expected entry names the instance it checks.
module tb_gray_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, load = 1'b0, load_gray = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] w_bin, w_gray, s_bin, s_gray;
    logic       w_tc, w_wp, s_tc, s_wp;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit       sel;
        logic [3:0] b;
        logic [3:0] g;
        bit       tc;
        bit       wp;
        bit       one;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [3:0] prev_g = '0;
    logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_counter #(.N(4), .WRAP(1'b1)) u_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .load_val(load_val), .bin_out(w_bin), .gray_out(w_gray), .tc(w_tc), .wrap_pulse(w_wp)
    );
    gray_counter #(.N(4), .WRAP(1'b0)) u_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .load_val(load_val), .bin_out(s_bin), .gray_out(s_gray), .tc(s_tc), .wrap_pulse(s_wp)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic exp_t mk(bit sel, logic [3:0] b, logic [3:0] g, bit t, bit wp, bit one);
        exp_t x;
        x.sel = sel; x.b = b; x.g = g; x.tc = t; x.wp = wp; x.one = one;
        return x;
    endfunction

    task automatic drive(input bit l, input bit lg, input bit en_i, input bit up_i,
                         input logic [3:0] lv, input exp_t x);
        @(negedge clk);
        load = l; load_gray = lg; en = en_i; up = up_i; load_val = lv;
        q.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk(e.sel ? "sat_bin" : "wrap_bin", e.sel ? s_bin : w_bin, e.b);
                chk(e.sel ? "sat_gray" : "wrap_gray", e.sel ? s_gray : w_gray, e.g);
                chk(e.sel ? "sat_tc" : "wrap_tc", e.sel ? s_tc : w_tc, e.tc);
                chk(e.sel ? "sat_wrap_pulse" : "wrap_wrap_pulse", e.sel ? s_wp : w_wp, e.wp);
                if (!e.sel) begin
                    if (e.one) chk("gray_one_bit_change", $countones(w_gray ^ prev_g), 1);
                    prev_g = w_gray;
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_bin", w_bin, 0);
        chk("rst_gray", w_gray, 0);
        chk("rst_wrap_pulse", w_wp, 0);
        chk("rst_tc_up", w_tc, 0);
        up = 1'b0;
        #1 chk("rst_tc_down", w_tc, 1);
        @(negedge clk);
        rst = 1'b0;
        up = 1'b1;
        for (int i = 0; i < 16; i++)
            drive(0, 0, 1, 1, 4'd0, mk(0, 4'(i + 1), gseq[(i + 1) % 16], (i == 14), (i == 15), 1));
        @(negedge clk);
        en = 1'b0; up = 1'b0;
        #1 chk("tc_at_zero_down", w_tc, 1);
        drive(0, 0, 1, 0, 4'd0, mk(0, 4'd15, 4'b1000, 0, 1, 1));
        drive(0, 0, 1, 0, 4'd0, mk(0, 4'd14, 4'b1001, 0, 0, 1));
        drive(0, 0, 1, 0, 4'd0, mk(0, 4'd13, 4'b1011, 0, 0, 1));
        drive(1, 1, 0, 0, 4'b1101, mk(0, 4'd9, 4'b1101, 0, 0, 0));
        drive(1, 0, 0, 0, 4'b0110, mk(0, 4'd6, 4'b0101, 0, 0, 0));
        drive(1, 0, 1, 1, 4'b0011, mk(0, 4'd3, 4'b0010, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            drive(0, 0, 0, 1, 4'd0, mk(0, 4'd3, 4'b0010, 0, 0, 0));
        drive(1, 0, 0, 1, 4'd14, mk(1, 4'd14, 4'b1001, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            drive(0, 0, 1, 1, 4'd0, mk(1, 4'd15, 4'b1000, 1, 0, 0));
        drive(1, 0, 0, 0, 4'd1, mk(1, 4'd1, 4'b0001, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            drive(0, 0, 1, 0, 4'd0, mk(1, 4'd0, 4'b0000, 1, 0, 0));
        drive(1, 0, 0, 1, 4'd7, mk(0, 4'd7, 4'b0100, 0, 0, 0));
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bin", w_bin, 0);
        chk("async_rst_gray", w_gray, 0);
        chk("async_rst_wrap_pulse", w_wp, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 1, 1, 4'd0, mk(0, 4'd1, 4'b0001, 0, 0, 0));
        drive(0, 0, 1, 1, 4'd0, mk(0, 4'd2, 4'b0011, 0, 0, 1));
        drive(0, 0, 1, 1, 4'd0, mk(0, 4'd3, 4'b0010, 0, 0, 1));
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
